serial_adder: RTL and testbench

- Parametrised, bit-serial successor to the team's combinational half/full adders: adds or subtracts two WIDTH-bit operands one bit per clock, LSB first, through a single full-adder slice.
- start/busy/done handshake; result and flags held until the next operation.
- Used where area matters more than latency, e.g. as an ALU helper or accumulator front-end in lab datapaths.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/full_adder.sv | 28 ++
 rtl/half_adder.sv | 10 +
 rtl/serial_adder.sv | 109 ++++++++++
 tb/tb_serial_adder.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 8;
    // Counter width for the default build; instances derive their own via cnt_width().
    localparam int CNT_W = $clog2(WIDTH_DEFAULT);

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder slice built from two half adders and an OR.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a    (a),
        .b    (b),
        .sum  (s0),
        .cout (c0)
    );

    half_adder u_ha1 (
        .a    (s0),
        .b    (cin),
        .sum  (sum),
        .cout (c1)
    );

    assign cout = c0 | c1;
endmodule

// File: rtl/half_adder.sv
// One-bit half adder: sum and carry of two input bits.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b;
    assign cout = a & b;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit add/subtract, LSB first through one full-adder slice.
// start/busy/done handshake; sum, cout and ovf hold until the next operation.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [WIDTH-1:0] res_sr_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic fa_sum;
    logic fa_cout;
    logic accept;
    logic last_bit;

    full_adder u_fa (
        .a    (a_sr_reg[0]),
        .b    (b_sr_reg[0]),
        .cin  (carry_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign accept   = start && (state_reg != RUN);
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = last_bit ? DONE : RUN;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == RUN);
        done = (state_reg == DONE);
    end

    // Working registers shift every RUN edge; the visible result registers
    // load only on the final edge so no partial sum is ever exposed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            res_sr_reg <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            sum_reg    <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else if (accept) begin
            a_sr_reg  <= a;
            b_sr_reg  <= sub ? ~b : b;
            carry_reg <= sub ? 1'b1 : cin;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            res_sr_reg <= {fa_sum, res_sr_reg[WIDTH-1:1]};
            a_sr_reg   <= a_sr_reg >> 1;
            b_sr_reg   <= b_sr_reg >> 1;
            carry_reg  <= fa_cout;
            cnt_reg    <= cnt_reg + 1'b1;
            if (last_bit) begin
                sum_reg  <= {fa_sum, res_sr_reg[WIDTH-1:1]};
                cout_reg <= fa_cout;
                // carry_reg here is the carry into the MSB slice
                ovf_reg  <= carry_reg ^ fa_cout;
            end
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 (directed + random) and WIDTH=4 (exhaustive).
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    logic       start4;
    logic       sub4;
    logic       cin4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;
    logic       ovf4;

    int total;
    int bad;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .sub   (sub4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4),
        .ovf   (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer arithmetic on unsigned and signed interpretations.
    function automatic void model(input int w, input logic s, input int x, input int y,
                                  input logic ci, output int r, output logic co,
                                  output logic ov);
        longint full;
        longint sx;
        longint sy;
        longint sres;
        longint lim;
        lim = longint'(1) << w;
        sx  = (x >= lim / 2) ? x - lim : x;
        sy  = (y >= lim / 2) ? y - lim : y;
        if (s) begin
            full = longint'(x) - longint'(y);
            sres = sx - sy;
            co   = (x >= y);
        end else begin
            full = longint'(x) + longint'(y) + longint'(ci);
            sres = sx + sy + longint'(ci);
            co   = (full >= lim);
        end
        r  = int'(((full % lim) + lim) % lim);
        ov = (sres < -(lim / 2)) || (sres > lim / 2 - 1);
    endfunction

    task automatic run_op(input logic s, input logic [7:0] x, input logic [7:0] y,
                          input logic ci, input string nm);
        int   er;
        logic ec;
        logic eo;
        int   lat;
        int   nb;
        model(8, s, int'(x), int'(y), ci, er, ec, eo);
        @(negedge clk);
        sub = s; a = x; b = y; cin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        nb  = 0;
        while (!done && lat < 40) begin
            if (busy) nb++;
            @(negedge clk);
            lat++;
        end
        $display("op %s: sub=%0b a=%02h b=%02h cin=%0b -> sum=%02h cout=%0b ovf=%0b lat=%0d busy=%0d",
                 nm, s, x, y, ci, sum, cout, ovf, lat, nb);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s timeout: done never seen within %0d cycles", nm, lat);
        end
        total++;
        if (lat !== 8) begin
            bad++;
            $display("FAIL %s latency: got %0d want 8", nm, lat);
        end
        total++;
        if (nb !== 8) begin
            bad++;
            $display("FAIL %s busy cycles: got %0d want 8", nm, nb);
        end
        total++;
        if (sum !== 8'(er) || cout !== ec || ovf !== eo || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s result: got sum=%02h cout=%0b ovf=%0b busy=%0b want sum=%02h cout=%0b ovf=%0b busy=0",
                     nm, sum, cout, ovf, busy, 8'(er), ec, eo);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || sum !== 8'(er) || cout !== ec || ovf !== eo) begin
            bad++;
            $display("FAIL %s hold: got done=%0b sum=%02h cout=%0b ovf=%0b want done=0 sum=%02h cout=%0b ovf=%0b",
                     nm, done, sum, cout, ovf, 8'(er), ec, eo);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: busy=%0b done=%0b sum=%02h cout=%0b ovf=%0b", busy, done, sum, cout, ovf);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0
            || busy4 !== 1'b0 || done4 !== 1'b0 || sum4 !== 4'h0) begin
            bad++;
            $display("FAIL reset state: got busy=%0b done=%0b sum=%02h cout=%0b ovf=%0b want all zero",
                     busy, done, sum, cout, ovf);
        end
    endtask

    task automatic test_directed;
        run_op(1'b0, 8'h0F, 8'h01, 1'b0, "add_0f_01");
        run_op(1'b0, 8'hFF, 8'h01, 1'b0, "add_ff_01");
        run_op(1'b0, 8'h7F, 8'h01, 1'b0, "add_7f_01");
        run_op(1'b1, 8'h05, 8'h07, 1'b0, "sub_05_07");
        run_op(1'b1, 8'h80, 8'h01, 1'b1, "sub_80_01");
        run_op(1'b0, 8'hFF, 8'hFF, 1'b1, "add_ff_ff_c");
        run_op(1'b1, 8'h00, 8'h00, 1'b0, "sub_00_00");
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            run_op(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_start_while_busy;
        int lat;
        @(negedge clk);
        sub = 1'b0; a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        sub = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 3;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        $display("busy_start: sum=%02h cout=%0b ovf=%0b lat=%0d", sum, cout, ovf, lat);
        total++;
        if (done !== 1'b1 || lat !== 8 || sum !== 8'h10 || cout !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL busy_start: got done=%0b lat=%0d sum=%02h cout=%0b ovf=%0b want done=1 lat=8 sum=10 cout=0 ovf=0",
                     done, lat, sum, cout, ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat;
        int gap;
        int   er;
        logic ec;
        logic eo;
        model(8, 1'b1, 8'h30, 8'h45, 1'b0, er, ec, eo);
        @(negedge clk);
        sub = 1'b0; a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (done !== 1'b1 || sum !== 8'h10) begin
            bad++;
            $display("FAIL b2b first: got done=%0b sum=%02h want done=1 sum=10", done, sum);
        end
        sub = 1'b1; a = 8'h30; b = 8'h45; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        gap = 1;
        while (!done && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        $display("b2b: second sum=%02h cout=%0b ovf=%0b gap=%0d", sum, cout, ovf, gap);
        total++;
        if (done !== 1'b1 || gap !== 9 || sum !== 8'(er) || cout !== ec || ovf !== eo) begin
            bad++;
            $display("FAIL b2b second: got done=%0b gap=%0d sum=%02h cout=%0b ovf=%0b want done=1 gap=9 sum=%02h cout=%0b ovf=%0b",
                     done, gap, sum, cout, ovf, 8'(er), ec, eo);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int seen;
        @(negedge clk);
        sub = 1'b0; a = 8'h40; b = 8'h21; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("reset_mid_run: busy=%0b done=%0b sum=%02h cout=%0b ovf=%0b", busy, done, sum, cout, ovf);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_run outputs: got busy=%0b done=%0b sum=%02h cout=%0b ovf=%0b want all zero",
                     busy, done, sum, cout, ovf);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL reset_mid_run abort: got %0d cycles with done/busy want 0", seen);
        end
        run_op(1'b0, 8'h03, 8'h04, 1'b1, "after_reset");
        total++;
        if (sum !== 8'h08) begin
            bad++;
            $display("FAIL after_reset sum: got %02h want 08", sum);
        end
    endtask

    task automatic test_sweep4;
        int   er;
        logic ec;
        logic eo;
        int   lat;
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    for (int ci = 0; ci < 2; ci++) begin
                        model(4, 1'(s), x, y, 1'(ci), er, ec, eo);
                        @(negedge clk);
                        sub4 = 1'(s); a4 = 4'(x); b4 = 4'(y); cin4 = 1'(ci); start4 = 1'b1;
                        @(negedge clk);
                        start4 = 1'b0;
                        lat = 0;
                        while (!done4 && lat < 20) begin
                            @(negedge clk);
                            lat++;
                        end
                        $display("w4: sub=%0d a=%0h b=%0h cin=%0d -> sum=%0h cout=%0b ovf=%0b lat=%0d",
                                 s, x, y, ci, sum4, cout4, ovf4, lat);
                        total++;
                        if (done4 !== 1'b1 || lat !== 4 || sum4 !== 4'(er) || cout4 !== ec || ovf4 !== eo) begin
                            bad++;
                            $display("FAIL w4 sub=%0d a=%0h b=%0h cin=%0d: got done=%0b lat=%0d sum=%0h cout=%0b ovf=%0b want done=1 lat=4 sum=%0h cout=%0b ovf=%0b",
                                     s, x, y, ci, done4, lat, sum4, cout4, ovf4, 4'(er), ec, eo);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
